quiescence_responder: RTL
=========================

Name: quiescence_responder

Overview:
- Per-slot endpoint of the quiescence protocol. Sits between one application and its AMI memory port.
- On a quiesce command it stops new memory requests from the app and drains outstanding reads and writes. It then reports "quiesced" to the quiescence controller over QuiescenceReq/QuiescenceResp.
- It also answers status checks and supports a resume command that re-opens the request path.

Parameters:
CNT_BITS, 8, width of the outstanding-read and outstanding-write counters; saturation point is 2^CNT_BITS-1.

Ports:
clk  in  1  user clock
rst_n  in  1  synchronous, active-low reset
qreq_valid  in  1  QuiescenceReq.valid from the controller
qreq_isRequest  in  1  1 = command (quiesce/resume), 0 = status check
qreq_data  in  64  bit0: 1 = quiesce, 0 = resume (commands only)
qresp_valid  out  1  QuiescenceResp.valid
qresp_data  out  64  status word (format below)
app_req_valid  in  1  app memory request valid
app_req_grant  out  1  grant returned to the app
mem_req_valid  out  1  request valid toward AMI
mem_req_grant  in  1  AMI accepts the request
app_req_isWrite  in  1  type of the current app request
mem_rd_resp_valid  in  1  read response valid from AMI
app_rd_resp_grant  in  1  app accepts the read response
mem_wr_ack  in  1  one-cycle write completion pulse
app_idle  in  1  app reports no internal work in flight (e.g. softreg)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=RUNNING; rd_cnt=0, wr_cnt=0, err=0.
  - qresp_valid=0, qresp_data=0.
  - Reset mid-drain discards all counts.
- Gating (combinational):
  - gate = (state!=RUNNING) | (app_req_isWrite ? wr_cnt==MAX : rd_cnt==MAX).
  - mem_req_valid = app_req_valid & ~gate.
  - app_req_grant = mem_req_grant & ~gate.
  - A request not yet granted may be withdrawn by the gate. A granted request is always counted.
- Counters (registered):
  - issue = mem_req_valid & mem_req_grant.
  - rd_done = mem_rd_resp_valid & app_rd_resp_grant.
  - wr_done = mem_wr_ack.
  - rd_cnt += (issue & ~isWrite) - rd_done; wr_cnt += (issue & isWrite) - wr_done.
  - Simultaneous issue and completion of the same type leaves the count unchanged.
  - A completion at count 0 holds the count at 0 and sets sticky err=1; only reset clears err.
  - Counts never wrap: the gate prevents increment past MAX.
- State machine (RUNNING, DRAINING, QUIESCED):
  - RUNNING: command with data[0]=1 -> DRAINING. Resume is ignored.
  - DRAINING: resume -> RUNNING. Otherwise, if rd_cnt==0 & wr_cnt==0 & app_idle & no issue/completion this cycle -> QUIESCED.
  - QUIESCED: resume -> RUNNING. Quiesce is ignored.
  - QUIESCED -> DRAINING if app_idle drops, or a completion arrives (error case; sets err if the count was 0).
  - The drain condition is evaluated on registered counts, so the earliest QUIESCED is 1 cycle after the last completion.
- Command and check behaviour:
  - Commands produce no response.
  - A status check (qreq_valid & ~qreq_isRequest) in cycle t drives qresp_valid=1 in t+1.
  - qresp_data in t+1 holds the values registered at the start of cycle t, before that cycle's update.
  - The controller may hold a check valid for many cycles; a response is produced every cycle it is held.
  - qresp_valid=0 in every other cycle.
- Status word:
  - bit0 = (state==QUIESCED); bit1 = err; bits[2] = (state==DRAINING).
  - bits[15:8] = rd_cnt (zero-extended/truncated to 8).
  - bits[23:16] = wr_cnt.
  - All other bits 0.

Test Plan:
1. Reset, then a check -> qresp_valid=1 next cycle, qresp_data=0x0 (RUNNING, counts 0).
2. Issue 3 reads + 2 writes, quiesce command, check -> data=0x0002_0304 (DRAINING); further app_req_valid sees app_req_grant=0 and mem_req_valid=0. Return 3 read responses + 2 write acks with app_idle=1 -> check data=0x1 within 2 cycles of the last ack.
3. Quiesce with 0 outstanding and app_idle=0 -> stays DRAINING (data=0x4); raise app_idle -> data=0x1 next check.
4. In QUIESCED, resume command (isRequest=1, data=0) -> next cycle app_req_grant follows mem_req_grant; check returns 0x0.
5. Read issue and read completion in the same cycle with rd_cnt=1 -> rd_cnt stays 1. Completion with rd_cnt=0 -> rd_cnt=0, check bit1=1, persists until rst_n=0.
6. CNT_BITS=2, 3 reads outstanding -> 4th read gated (mem_req_valid=0) while writes still pass. Assert rst_n=0 mid-drain -> all counts 0, state RUNNING, qresp_valid=0.

Source files
------------

// File: rtl/quiescence_responder.sv
// Per-slot quiescence endpoint between one app and its AMI memory port.
// Gates new requests, drains outstanding traffic, answers status checks.
module quiescence_responder #(
  parameter int CNT_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        qreq_valid,
  input  logic        qreq_isRequest,
  input  logic [63:0] qreq_data,
  output logic        qresp_valid,
  output logic [63:0] qresp_data,
  input  logic        app_req_valid,
  output logic        app_req_grant,
  output logic        mem_req_valid,
  input  logic        mem_req_grant,
  input  logic        app_req_isWrite,
  input  logic        mem_rd_resp_valid,
  input  logic        app_rd_resp_grant,
  input  logic        mem_wr_ack,
  input  logic        app_idle
);

  typedef enum logic [1:0] {
    RUNNING,
    DRAINING,
    QUIESCED
  } state_t;

  localparam logic [CNT_BITS-1:0] MAX = '1;
  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  state_t state_q, state_d;
  logic [CNT_BITS-1:0] rd_cnt, wr_cnt;
  logic [CNT_BITS-1:0] rd_cnt_d, wr_cnt_d;
  logic err, err_d;

  logic gate, issue, issue_rd, issue_wr;
  logic rd_done, wr_done, busy;
  logic cmd, quiesce_cmd, resume_cmd, check;
  logic [31:0] rd_ext, wr_ext;
  logic [63:0] status;
  logic unused;

  assign gate = (state_q != RUNNING) |
                (app_req_isWrite ? (wr_cnt == MAX)
                                 : (rd_cnt == MAX));
  assign mem_req_valid = app_req_valid & ~gate;
  assign app_req_grant = mem_req_grant & ~gate;

  assign issue    = mem_req_valid & mem_req_grant;
  assign issue_rd = issue & ~app_req_isWrite;
  assign issue_wr = issue & app_req_isWrite;
  assign rd_done  = mem_rd_resp_valid & app_rd_resp_grant;
  assign wr_done  = mem_wr_ack;
  assign busy     = issue | rd_done | wr_done;

  assign cmd         = qreq_valid & qreq_isRequest;
  assign quiesce_cmd = cmd & qreq_data[0];
  assign resume_cmd  = cmd & ~qreq_data[0];
  assign check       = qreq_valid & ~qreq_isRequest;

  assign rd_ext = 32'(rd_cnt);
  assign wr_ext = 32'(wr_cnt);
  assign status = {40'b0, wr_ext[7:0], rd_ext[7:0], 5'b0,
                   state_q == DRAINING, err,
                   state_q == QUIESCED};
  assign unused = ^{qreq_data[63:1], rd_ext[31:8], wr_ext[31:8]};

  // An underflowing completion holds the count and flags the error.
  always_comb begin
    rd_cnt_d = rd_cnt;
    wr_cnt_d = wr_cnt;
    err_d    = err;
    if (issue_rd & ~rd_done) begin
      rd_cnt_d = rd_cnt + ONE;
    end else if (~issue_rd & rd_done) begin
      if (rd_cnt == '0) err_d = 1'b1;
      else rd_cnt_d = rd_cnt - ONE;
    end
    if (issue_wr & ~wr_done) begin
      wr_cnt_d = wr_cnt + ONE;
    end else if (~issue_wr & wr_done) begin
      if (wr_cnt == '0) err_d = 1'b1;
      else wr_cnt_d = wr_cnt - ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUNNING: begin
        if (quiesce_cmd) state_d = DRAINING;
      end
      DRAINING: begin
        if (resume_cmd) state_d = RUNNING;
        else if (rd_cnt == '0 && wr_cnt == '0 &&
                 app_idle && !busy)
          state_d = QUIESCED;
      end
      QUIESCED: begin
        if (resume_cmd) state_d = RUNNING;
        else if (!app_idle || rd_done || wr_done)
          state_d = DRAINING;
      end
      default: state_d = RUNNING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUNNING;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      err         <= 1'b0;
      qresp_valid <= 1'b0;
      qresp_data  <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt      <= rd_cnt_d;
      wr_cnt      <= wr_cnt_d;
      err         <= err_d;
      qresp_valid <= check;
      qresp_data  <= check ? status : '0;
    end
  end

endmodule
